// File: rtl/npu_pkg.sv
// Shared widths and the int8 saturation helper for the UniNPU convolution datapath.
package npu_pkg;
  localparam int DATA_W = 8;
  localparam int TAPS   = 9;
  localparam int BIAS_W = 16;
  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = 20;
  localparam int ACC_W  = 21;
  localparam int Q_W    = ACC_W + 1;

  // Clamp a wide signed value into [-128, 127].
  function automatic logic signed [DATA_W-1:0] sat_int8(input logic signed [Q_W-1:0] v);
    if (!v[Q_W-1] && (|v[Q_W-2:DATA_W-1]))
      return 8'sh7F;
    else if (v[Q_W-1] && !(&v[Q_W-2:DATA_W-1]))
      return 8'sh80;
    else
      return v[DATA_W-1:0];
  endfunction
endpackage

// File: rtl/arithmetic_core_mac9.sv
// Nine signed 8x8 multipliers registered at stage 1, then an adder tree plus bias.
module mac9
  import npu_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [TAPS*DATA_W-1:0]  act,
  input  logic [TAPS*DATA_W-1:0]  wgt,
  input  logic [BIAS_W-1:0]       bias,
  output logic signed [ACC_W-1:0] acc_p1,
  output logic                    vld_p1
);
  logic signed [PROD_W-1:0] prod_p1_d [TAPS];
  logic signed [PROD_W-1:0] prod_p1_q [TAPS];
  logic signed [BIAS_W-1:0] bias_p1_q;
  logic                     vld_p1_d, vld_p1_q;
  logic signed [SUM_W-1:0]  sum_p1;

  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      prod_p1_d[k] = $signed(act[(TAPS-1-k)*DATA_W +: DATA_W]) *
                     $signed(wgt[(TAPS-1-k)*DATA_W +: DATA_W]);
    end
    vld_p1_d = en;
  end

  // stage 1: products and bias
  always_ff @(posedge clk) begin
    if (reset) vld_p1_q <= 1'b0;
    else       vld_p1_q <= vld_p1_d;
    if (en) begin
      prod_p1_q <= prod_p1_d;
      bias_p1_q <= $signed(bias);
    end
  end

  always_comb begin
    sum_p1 = '0;
    for (int k = 0; k < TAPS; k++) begin
      sum_p1 = sum_p1 + SUM_W'(prod_p1_q[k]);
    end
    acc_p1 = ACC_W'(sum_p1) + ACC_W'(bias_p1_q);
  end

  assign vld_p1 = vld_p1_q;
endmodule

// File: rtl/arithmetic_core.sv
// Convolution core: mac9 dot product, then requantize, saturate, ReLU and optional max-pool.
module arithmetic_core
  import npu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [71:0] in,
  input  logic [71:0] weightin,
  input  logic [15:0] bias,
  input  logic [2:0]  bound_level,
  input  logic [2:0]  step,
  input  logic        en,
  input  logic        en_relu,
  input  logic        en_mp,
  output logic [7:0]  out,
  output logic        out_en
);
  logic signed [ACC_W-1:0]  acc_p1;
  logic                     vld_p1;
  logic [2:0]               bl_p1_q, step_p1_q;
  logic                     relu_p1_q, mp_p1_q;

  logic signed [DATA_W-1:0] res_p2_d, res_p2_q;
  logic [2:0]               step_p2_q;
  logic                     mp_p2_q, vld_p2_q;

  logic signed [DATA_W-1:0] out_d, out_q, max_d, max_q, cur_max;
  logic                     out_en_d, out_en_q;
  logic [2:0]               cnt_d, cnt_q;

  // Round half up, then arithmetic shift right by sh.
  function automatic logic signed [Q_W-1:0] requant(input logic signed [ACC_W-1:0] a,
                                                    input logic [2:0] sh);
    logic signed [Q_W-1:0] ext, one;
    ext = {a[ACC_W-1], a};
    one = 1;
    if (sh == 3'd0) return ext;
    return (ext + (one <<< (sh - 3'd1))) >>> sh;
  endfunction

  function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] v,
                                                    input logic enable);
    return (enable && v < 0) ? 8'sh00 : v;
  endfunction

  mac9 u_mac9 (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .act    (in),
    .wgt    (weightin),
    .bias   (bias),
    .acc_p1 (acc_p1),
    .vld_p1 (vld_p1)
  );

  // stage 1: per-sample configuration travels with the products
  always_ff @(posedge clk) begin
    if (en) begin
      bl_p1_q   <= bound_level;
      step_p1_q <= step;
      relu_p1_q <= en_relu;
      mp_p1_q   <= en_mp;
    end
  end

  always_comb res_p2_d = relu(sat_int8(requant(acc_p1, bl_p1_q)), relu_p1_q);

  // stage 2: requantized int8 result
  always_ff @(posedge clk) begin
    if (reset) vld_p2_q <= 1'b0;
    else       vld_p2_q <= vld_p1;
    if (vld_p1) begin
      res_p2_q  <= res_p2_d;
      step_p2_q <= step_p1_q;
      mp_p2_q   <= mp_p1_q;
    end
  end

  always_comb begin
    out_d    = out_q;
    out_en_d = 1'b0;
    cnt_d    = cnt_q;
    max_d    = max_q;
    cur_max  = (cnt_q == 3'd0 || res_p2_q > max_q) ? res_p2_q : max_q;
    if (vld_p2_q) begin
      if (!mp_p2_q) begin
        out_d    = res_p2_q;
        out_en_d = 1'b1;
        cnt_d    = 3'd0;
      end else if (cnt_q == step_p2_q) begin
        out_d    = cur_max;
        out_en_d = 1'b1;
        cnt_d    = 3'd0;
        max_d    = 8'sh00;
      end else begin
        cnt_d = cnt_q + 3'd1;
        max_d = cur_max;
      end
    end
  end

  // stage 3: bypass or pooled output
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q    <= 8'sh00;
      out_en_q <= 1'b0;
      cnt_q    <= 3'd0;
      max_q    <= 8'sh00;
    end else begin
      out_q    <= out_d;
      out_en_q <= out_en_d;
      cnt_q    <= cnt_d;
      max_q    <= max_d;
    end
  end

  assign out    = out_q;
  assign out_en = out_en_q;
endmodule

// File: tb/tb_arithmetic_core.sv
// Directed bench for arithmetic_core with a small golden model for the random bypass run.
module tb_arithmetic_core;
  logic        clk = 1'b0;
  logic        reset;
  logic [71:0] in, weightin;
  logic [15:0] bias;
  logic [2:0]  bound_level, step;
  logic        en, en_relu, en_mp;
  logic [7:0]  out;
  logic        out_en;

  int checks = 0;
  int failures = 0;

  arithmetic_core dut (
    .clk(clk), .reset(reset), .in(in), .weightin(weightin), .bias(bias),
    .bound_level(bound_level), .step(step), .en(en), .en_relu(en_relu),
    .en_mp(en_mp), .out(out), .out_en(out_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] tap0(input int v);
    logic [7:0] b;
    b = v[7:0];
    return {b, 64'd0};
  endfunction

  function automatic int golden(input logic [71:0] a, input logic [71:0] w,
                                input logic [15:0] b, input int bl, input logic rl);
    int acc, t, d, q;
    acc = int'($signed(b));
    for (int k = 0; k < 9; k++)
      acc += int'($signed(a[(8-k)*8 +: 8])) * int'($signed(w[(8-k)*8 +: 8]));
    if (bl == 0) q = acc;
    else begin
      d = 1 << bl;
      t = acc + d / 2;
      q = (t >= 0) ? t / d : -((-t + d - 1) / d);
    end
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    if (rl && q < 0) q = 0;
    return q;
  endfunction

  function automatic int sout();
    return int'($signed(out));
  endfunction

  task automatic single(input string tag, input logic [71:0] a, input logic [71:0] w,
                        input logic [15:0] b, input logic [2:0] bl, input logic rl,
                        input int exp);
    @(negedge clk);
    in = a; weightin = w; bias = b; bound_level = bl; en_relu = rl; en_mp = 1'b0;
    step = 3'd0; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check({tag, "_early"}, int'(out_en), 0);
    @(negedge clk);
    check({tag, "_vld"}, int'(out_en), 1);
    check(tag, sout(), exp);
    @(negedge clk);
    check({tag, "_pulse"}, int'(out_en), 0);
  endtask

  task automatic pool_seq(input string tag, input int vals[4], input int stp, input int exp);
    int pulses, last;
    pulses = 0; last = -999;
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      if (out_en) begin pulses++; last = sout(); end
      if (j <= stp) begin
        in = tap0(vals[j]); weightin = tap0(1); bias = 16'd0; bound_level = 3'd0;
        en_relu = 1'b0; en_mp = 1'b1; step = 3'(stp); en = 1'b1;
      end else en = 1'b0;
    end
    check({tag, "_pulses"}, pulses, 1);
    check(tag, last, exp);
  endtask

  initial begin
    int exp_q[$];
    int run, e;
    logic [71:0] a, w;
    logic [15:0] b;
    logic [2:0]  bl;
    logic        rl;

    reset = 1'b1; en = 1'b0; in = '0; weightin = '0; bias = '0;
    bound_level = '0; step = '0; en_relu = 1'b0; en_mp = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_out", sout(), 0);
    check("rst_out_en", int'(out_en), 0);

    single("ones", {9{8'd1}}, {9{8'd1}}, 16'd0, 3'd0, 1'b1, 9);
    single("neg9", {9{8'd1}}, {9{8'hFF}}, 16'd0, 3'd0, 1'b0, -9);
    single("neg9_relu", {9{8'd1}}, {9{8'hFF}}, 16'd0, 3'd0, 1'b1, 0);
    single("sat_hi", {9{8'd127}}, {9{8'd127}}, 16'd0, 3'd0, 1'b0, 127);
    single("sat_lo", {9{8'd127}}, {9{8'h80}}, 16'd0, 3'd0, 1'b0, -128);
    single("rq_pos", tap0(16), tap0(1), 16'd4, 3'd3, 1'b0, 3);
    single("rq_neg", '0, '0, 16'hFFD8, 3'd2, 1'b0, -10);

    // 64 back-to-back random windows in bypass
    run = 0;
    for (int j = 0; j < 67; j++) begin
      @(negedge clk);
      if (j >= 3) begin
        e = exp_q.pop_front();
        check("rand_vld", int'(out_en), 1);
        check("rand_out", sout(), e);
        if (out_en) run++;
      end
      if (j < 64) begin
        for (int k = 0; k < 9; k++) begin
          a[k*8 +: 8] = 8'($urandom);
          w[k*8 +: 8] = 8'($urandom);
        end
        b = 16'($urandom_range(0, 4095)) - 16'd2048;
        bl = 3'($urandom_range(0, 7));
        rl = 1'($urandom);
        in = a; weightin = w; bias = b; bound_level = bl; en_relu = rl;
        en_mp = 1'b0; step = 3'd0; en = 1'b1;
        exp_q.push_back(golden(a, w, b, int'(bl), rl));
      end else en = 1'b0;
    end
    check("rand_run", run, 64);
    @(negedge clk);
    check("rand_tail", int'(out_en), 0);

    pool_seq("pool4", '{5, -2, 9, 1}, 3, 9);
    pool_seq("pool_step0", '{7, 0, 0, 0}, 0, 7);

    // two results into a window, then reset clears the partial window
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (j < 2) begin
        in = tap0(j == 0 ? 5 : -2); weightin = tap0(1); bias = '0; bound_level = '0;
        en_relu = 1'b0; en_mp = 1'b1; step = 3'd3; en = 1'b1;
      end else en = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_out", sout(), 0);
    check("mid_rst_en", int'(out_en), 0);
    pool_seq("pool_after_rst", '{4, 3, 2, 1}, 3, 4);

    // input sampled on the reset edge must never emerge
    @(negedge clk);
    in = {9{8'd2}}; weightin = {9{8'd2}}; en_mp = 1'b0; en = 1'b1; reset = 1'b1;
    @(negedge clk);
    en = 1'b0; reset = 1'b0;
    run = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_en) run++;
    end
    check("rst_discard", run, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
